instr_loader: RTL and testbench
===============================

# instr_loader

Boot-time program loader sitting directly upstream of the single-cycle MIPS core's instruction memory. Accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them into the instruction-memory write port. After the programmed word count is written it releases the core for execution via `core_run`, which drives the core's active-low `Reset`.

## Interface
- `ADDR_W`, default 5: instruction-memory word-address width (32 words).
- `MAX_WORDS`, default 32: largest legal program length; must be ≤ 2^ADDR_W.
- `clk`  in  1  rising-edge clock, shared with the core.
- `Reset`  in  1  asynchronous, active-high reset.
- `s_valid`  in  1  byte on `s_data` is valid.
- `s_data`  in  8  stream byte.
- `s_ready`  out  1  loader can accept a byte this cycle.
- `im_we`  out  1  instruction-memory write strobe, one-cycle pulse per word.
- `im_addr`  out  ADDR_W  word address for the write.
- `im_wdata`  out  32  instruction word for the write.
- `core_run`  out  1  1 = core may execute; connects to the core's active-low `Reset`.
- `done`  out  1  load finished successfully.
- `error`  out  1  load aborted.
- `word_count`  out  ADDR_W+1  number of words written so far.

## Operation
- A byte is accepted only on a cycle where `s_valid && s_ready`. No other cycle has any effect.
- States and `s_ready` value:
  - IDLE, LOAD, CHECK: `s_ready`=1.
  - DONE, ERROR: `s_ready`=0.
- IDLE: the accepted byte is header N, the word count.
  - N=0 or N>MAX_WORDS → ERROR.
  - Otherwise latch N, clear the byte index and word index, go to LOAD.
- LOAD: byte k (k=0..3) of the current word goes to bits [31-8k:24-8k]. The first byte received is the MSB.
- When the 4th byte is accepted:
  - Next cycle: `im_we`=1, `im_addr`=word index, `im_wdata`=the assembled word.
  - The word index increments and `word_count` increments on that same edge.
- After the N-th word is accepted:
  - With the checksum feature: go to CHECK.
  - Without it: go to DONE.
  - The transition happens on the edge where the final `im_we` is asserted.
- CHECK: accept one byte.
  - Byte equals the mod-256 sum of all 4N payload bytes (header excluded) → DONE.
  - Otherwise → ERROR.
- DONE: `done`=1 and `core_run`=1. The state is held until `Reset`.
- ERROR: `error`=1 and `core_run`=0. The state is held until `Reset`. A partial word is never written.
- The only exit from DONE or ERROR is `Reset`.

## Timing
- Reset values: state=IDLE, `s_ready`=0 while `Reset` is high, then 1 in the first cycle after release. All other outputs are 0: `im_we`, `im_addr`, `im_wdata`, `core_run`, `done`, `error`, `word_count`.
- `Reset` asserted mid-load: asynchronous clear. The partial word and running checksum are discarded, any pending `im_we` is cancelled, and the next load restarts from the header.
- Write latency: `im_we` rises 1 cycle after the 4th byte of a word is accepted.
- Back-to-back bytes are sustainable at 1 byte/cycle. `s_ready` does not deassert between words.
- `im_addr` and `im_wdata` are registered and stable for the whole `im_we` cycle.
- `core_run` and `done` rise 1 cycle after the final `im_we` (no checksum), or 1 cycle after the checksum byte is accepted (with checksum).
- `error` rises 1 cycle after the offending byte is accepted.
- `s_valid` gaps of any length only stall the loader. Neither the byte index nor the checksum changes while stalled.
- The checksum accumulator is 8 bits and wraps silently.
- `word_count` saturates naturally at N; it never exceeds MAX_WORDS.

## Configuration
- `INSTR_LOADER_CHECKSUM_EN` defined:
  - CHECK state present.
  - One trailing checksum byte is required after the payload.
  - A mismatch leads to ERROR.
- `INSTR_LOADER_CHECKSUM_EN` undefined:
  - No CHECK state and no accumulator logic.
  - The loader goes directly to DONE after the N-th word.
  - Any byte after the payload is refused (`s_ready`=0).

## Test plan
- Checksum disabled, stream 02 01 2A 88 20 A1 49 00 00 → two write pulses, 0x012A8820 to address 0 and then 0xA1490000 to address 1. `word_count`=2. `core_run`=`done`=1 one cycle after the second pulse.
- Same stream with random `s_valid` gaps of 0–5 cycles → identical writes and final state. `im_we` is never high during a gap that is not at a word boundary.
- Checksum enabled, stream 01 A1 29 00 00 CA → write 0xA1290000 to address 0, then DONE. Replace the last byte with CB → ERROR, `error`=1, `core_run`=0, `s_ready`=0.
- Header 00, and separately header 21 (33) with MAX_WORDS=32 → ERROR after 1 cycle, no `im_we` pulse.
- `Reset` pulsed after 6 payload bytes of a 2-word load → no write for word 1, all outputs 0. A complete stream afterwards loads correctly starting from address 0.
- Stream 20 followed by 128 bytes (full 32-word program) → addresses 0..31 are written in order and `word_count`=32 at completion.

Source files
------------

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instr_loader
//  Description : Boot-time program loader for the single-cycle MIPS core.
//                Receives a byte stream (header N, then 4*N big-endian
//                payload bytes), writes each assembled 32-bit word into the
//                instruction memory and then releases the core via core_run.
//                Optional trailing checksum byte when the macro
//                INSTR_LOADER_CHECKSUM_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_loader #(
    parameter int ADDR_W    = 5,
    parameter int MAX_WORDS = 32
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              core_run,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
`ifdef INSTR_LOADER_CHECKSUM_EN
        ST_CHECK = 3'd2,
`endif
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [23:0]        shift_q, shift_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic [CNT_W-1:0]   word_count_q, word_count_d;
    logic               im_we_q, im_we_d;
    logic [ADDR_W-1:0]  im_addr_q, im_addr_d;
    logic [31:0]        im_wdata_q, im_wdata_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif

    logic               w_ready_state;
    logic               w_accept;
    logic               w_hdr_bad;

    // Ready is a function of state only, forced low while reset is held
    always_comb begin
        w_ready_state = 1'b0;
        case (state_q)
            ST_IDLE,
`ifdef INSTR_LOADER_CHECKSUM_EN
            ST_CHECK,
`endif
            ST_LOAD:  w_ready_state = 1'b1;
            default:  w_ready_state = 1'b0;
        endcase
    end

    assign s_ready   = w_ready_state && !Reset;
    assign w_accept  = s_valid && s_ready;
    assign w_hdr_bad = (s_data == 8'd0) || (int'(s_data) > MAX_WORDS);

    // Next-state, word assembly and write-strobe generation
    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        shift_d      = shift_q;
        n_d          = n_q;
        word_count_d = word_count_q;
        im_we_d      = 1'b0;
        im_addr_d    = im_addr_q;
        im_wdata_d   = im_wdata_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_hdr_bad) begin
                        state_d = ST_ERROR;
                    end else begin
                        n_d          = CNT_W'(s_data);
                        byte_idx_d   = 2'd0;
                        word_count_d = '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                        csum_d       = 8'd0;
`endif
                        state_d      = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (w_accept) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                    csum_d = csum_q + s_data;
`endif
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        // Word complete: launch the write, count it now so the
                        // final-word decision is made on this same edge.
                        im_we_d      = 1'b1;
                        im_addr_d    = word_count_q[ADDR_W-1:0];
                        im_wdata_d   = {shift_q, s_data};
                        word_count_d = word_count_q + c_cnt_one;
                        if (word_count_d == n_q) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                            state_d = ST_CHECK;
`else
                            state_d = ST_DONE;
`endif
                        end
                    end else begin
                        shift_d = {shift_q[15:0], s_data};
                    end
                end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (w_accept) begin
                    state_d = (s_data == csum_q) ? ST_DONE : ST_ERROR;
                end
            end
`endif
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            byte_idx_q   <= 2'd0;
            shift_q      <= 24'd0;
            n_q          <= '0;
            word_count_q <= '0;
            im_we_q      <= 1'b0;
            im_addr_q    <= '0;
            im_wdata_q   <= 32'd0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum_q       <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            shift_q      <= shift_d;
            n_q          <= n_d;
            word_count_q <= word_count_d;
            im_we_q      <= im_we_d;
            im_addr_q    <= im_addr_d;
            im_wdata_q   <= im_wdata_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    // DONE is entered on the edge that raises the final write strobe; holding
    // done off during that strobe makes it rise one cycle after the last write.
    assign done       = (state_q == ST_DONE) && !im_we_q;
    assign core_run   = done;
    assign error      = (state_q == ST_ERROR);
    assign im_we      = im_we_q;
    assign im_addr    = im_addr_q;
    assign im_wdata   = im_wdata_q;
    assign word_count = word_count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_loader
//  Description : Randomized self-checking bench for instr_loader with a
//                stream-level reference model (expected writes, latencies
//                and final status derived from the byte stream).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_loader;

    localparam int ADDR_W    = 5;
    localparam int MAX_WORDS = 32;
`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              Reset = 1'b1;
    logic              s_valid = 1'b0;
    logic [7:0]        s_data = 8'd0;
    logic              s_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              core_run;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   word_count;

    instr_loader #(
        .ADDR_W    (ADDR_W),
        .MAX_WORDS (MAX_WORDS)
    ) u_dut (
        .clk        (clk),
        .Reset      (Reset),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .core_run   (core_run),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus and observation records
    logic [7:0]        stim[$];
    int                acc[$];
    logic [ADDR_W-1:0] wr_addr[$];
    logic [31:0]       wr_data[$];
    int                wr_cyc[$];
    int                done_cyc = -1;
    int                err_cyc  = -1;
    bit                bad_run  = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observe writes and status edges once per cycle
    always @(negedge clk) begin
        if (!Reset) begin
            if (im_we) begin
                wr_addr.push_back(im_addr);
                wr_data.push_back(im_wdata);
                wr_cyc.push_back(cyc);
            end
            if (done && done_cyc < 0) done_cyc = cyc;
            if (error && err_cyc < 0) err_cyc = cyc;
            if ((core_run !== done) || (done && error)) bad_run = 1'b1;
        end
    end

    function automatic int acc_at(input int i);
        return (i < acc.size()) ? acc[i] : -100;
    endfunction

    task automatic add_byte(input logic [7:0] b);
        stim.push_back(b);
    endtask

    task automatic add_word(input logic [31:0] w);
        stim.push_back(w[31:24]);
        stim.push_back(w[23:16]);
        stim.push_back(w[15:8]);
        stim.push_back(w[7:0]);
    endtask

    function automatic logic [7:0] payload_sum(input int n);
        logic [7:0] s = 8'd0;
        for (int j = 1; j <= 4 * n; j++) s = s + stim[j];
        return s;
    endfunction

    task automatic enter_reset(input string name);
        @(posedge clk); #1;
        Reset   = 1'b1;
        s_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        check({name, ".rst_s_ready"},  s_ready,    0);
        check({name, ".rst_im_we"},    im_we,      0);
        check({name, ".rst_im_addr"},  im_addr,    0);
        check({name, ".rst_im_wdata"}, im_wdata,   0);
        check({name, ".rst_core_run"}, core_run,   0);
        check({name, ".rst_done"},     done,       0);
        check({name, ".rst_error"},    error,      0);
        check({name, ".rst_wcount"},   word_count, 0);
    endtask

    task automatic leave_reset(input string name);
        @(posedge clk); #1;
        Reset = 1'b0;
        acc.delete();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cyc = -1;
        err_cyc  = -1;
        bad_run  = 1'b0;
        @(negedge clk);
        check({name, ".ready_after_rst"}, s_ready, 1);
    endtask

    // Offer every stim byte; a byte refused for 8 cycles is dropped
    task automatic send_stim(input int gap_max);
        @(posedge clk); #1;
        for (int i = 0; i < stim.size(); i++) begin
            int gap;
            gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (gap) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
            s_valid = 1'b1;
            s_data  = stim[i];
            for (int w = 0; w < 8; w++) begin
                bit got;
                @(negedge clk);
                got = s_ready;
                if (got) acc.push_back(cyc);
                @(posedge clk); #1;
                if (got) break;
            end
            s_valid = 1'b0;
        end
    endtask

    // Reference model: derive the expected outcome from the stream alone
    task automatic eval_case(input string name);
        int n, exp_acc, exp_nw, exp_flag, nw;
        bit exp_done, exp_err;
        repeat (3) @(negedge clk);
        n        = int'(stim[0]);
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (n == 0 || n > MAX_WORDS) begin
            exp_acc  = 1;
            exp_nw   = 0;
            exp_err  = 1'b1;
            exp_flag = acc_at(0) + 1;
        end else if (CK) begin
            exp_acc  = 4 * n + 2;
            exp_nw   = n;
            exp_done = (stim[4 * n + 1] == payload_sum(n));
            exp_err  = !exp_done;
            exp_flag = acc_at(4 * n + 1) + 1;
        end else begin
            exp_acc  = 4 * n + 1;
            exp_nw   = n;
            exp_done = 1'b1;
            exp_flag = acc_at(4 * n) + 2;
        end
        check({name, ".accepted"}, acc.size(), exp_acc);
        check({name, ".writes"},   wr_addr.size(), exp_nw);
        nw = (wr_addr.size() < exp_nw) ? wr_addr.size() : exp_nw;
        for (int i = 0; i < nw; i++) begin
            check($sformatf("%s.wr%0d_addr", name, i), wr_addr[i], i);
            check($sformatf("%s.wr%0d_data", name, i), wr_data[i],
                  {stim[4*i+1], stim[4*i+2], stim[4*i+3], stim[4*i+4]});
            check($sformatf("%s.wr%0d_cyc", name, i), wr_cyc[i], acc_at(4*i+4) + 1);
        end
        check({name, ".done"},     done,       exp_done);
        check({name, ".error"},    error,      exp_err);
        check({name, ".core_run"}, core_run,   exp_done);
        check({name, ".s_ready"},  s_ready,    0);
        check({name, ".wcount"},   word_count, exp_nw);
        check({name, ".done_cyc"}, done_cyc,   exp_done ? exp_flag : -1);
        check({name, ".err_cyc"},  err_cyc,    exp_err  ? exp_flag : -1);
        check({name, ".run_eq_done"}, bad_run, 0);
    endtask

    task automatic run_case(input string name, input int gap_max);
        enter_reset(name);
        leave_reset(name);
        send_stim(gap_max);
        eval_case(name);
    endtask

    task automatic build_basic();
        stim.delete();
        add_byte(8'h02);
        add_word(32'h012A8820);
        add_word(32'hA1490000);
        if (CK) add_byte(payload_sum(2));
    endtask

    task automatic build_random(input int n, input bit bad_ck, input bit extra);
        stim.delete();
        add_byte(8'(n));
        for (int j = 0; j < 4 * n; j++) add_byte(8'($urandom_range(255, 0)));
        if (CK) add_byte(bad_ck ? payload_sum(n) + 8'($urandom_range(255, 1))
                                : payload_sum(n));
        if (extra) add_byte(8'($urandom_range(255, 0)));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        build_basic();
        run_case("basic", 0);
        build_basic();
        run_case("gaps", 5);

        stim.delete();
        add_byte(8'h01); add_word(32'hA1290000); add_byte(8'hCA);
        run_case("ck_ok", 0);
        stim.delete();
        add_byte(8'h01); add_word(32'hA1290000); add_byte(8'hCB);
        run_case("ck_bad", 1);

        stim.delete();
        add_byte(8'h00); add_byte(8'h11); add_byte(8'h22);
        run_case("hdr0", 0);
        stim.delete();
        add_byte(8'h21); add_word(32'h01020304);
        run_case("hdr33", 0);

        // Reset after six payload bytes: only word 0 may have been written
        enter_reset("midrst");
        leave_reset("midrst");
        stim.delete();
        add_byte(8'h02); add_word(32'h012A8820); add_byte(8'hA1); add_byte(8'h49);
        send_stim(0);
        enter_reset("midrst_hold");
        check("midrst.writes", wr_addr.size(), 1);
        if (wr_addr.size() > 0) begin
            check("midrst.wr0_addr", wr_addr[0], 0);
            check("midrst.wr0_data", wr_data[0], 32'h012A8820);
        end
        leave_reset("after_rst");
        build_basic();
        send_stim(2);
        eval_case("after_rst");

        build_random(32, 1'b0, 1'b0);
        run_case("full32", 3);

        for (int t = 0; t < 6; t++) begin
            build_random(int'($urandom_range(8, 1)), ($urandom_range(2, 0) == 0),
                         ($urandom_range(1, 0) == 1));
            run_case($sformatf("rand%0d", t), int'($urandom_range(3, 0)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
